twos_to_signmag: RTL
====================

Name: twos_to_signmag

Overview:
- Bit-serial converter from n-bit two's-complement words to sign-magnitude. It is the decode direction of the team's complement datapath.
- Operation is sequenced by a one-hot timing-pulse ring (T0..Tn), the same style used by the complement units.
- Processes the word LSB-first using the copy-until-first-one-then-invert rule: one bit per clock, with a start/done handshake.
- Sits after the complement stage to recover operands for display and compare logic.

Parameters:
- N_BITS, 8, word width of din and mag (minimum 2).
- PULSES, N_BITS+1, number of timing pulses: T0 is idle/load, T1..TN process bits 0..N_BITS-1. Derived; do not override.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion; sampled only while busy=0.
- din  input  N_BITS  two's-complement operand, sampled on the accepted start edge.
- busy  output  1  high while a conversion is in progress (pulses T1..TN).
- done  output  1  one-cycle pulse when mag/sign become valid.
- sign  output  1  sign of the accepted operand (din[N_BITS-1]).
- mag  output  N_BITS  unsigned magnitude, |din|.
- tp  output  PULSES  one-hot timing-pulse vector, exported for debug and bench checking.

Behaviour:
- Reset (async, rst=1): tp=1 (T0), busy=0, done=0, sign=0, mag=0, shift register and seen_one cleared. All outputs hold these values while rst is high.
- Idle (T0):
  - If start=1 at a clock edge: load shreg<=din, sign<=din[N_BITS-1], seen_one<=0, mag<=0, tp<=T1, busy<=1.
  - Otherwise remain in T0. done is 0 in all states except the completion cycle.
- Processing (Tk, k=1..N_BITS): on each edge, with b=shreg[0]:
  - If sign=0: out_bit=b.
  - If sign=1: out_bit = seen_one ? ~b : b, then seen_one <= seen_one | b.
  - mag <= {out_bit, mag[N_BITS-1:1]}; shreg >> 1.
  - tp rotates to T(k+1); after TN it returns to T0.
- Completion: on the edge leaving TN, tp<=T0, busy<=0, done<=1 for exactly one cycle.
  - mag and sign hold until the next accepted start.
  - Latency: start edge to done high is N_BITS+1 edges (9 for N_BITS=8).
- Back-to-back: start may be asserted in the same cycle done=1. It is accepted because busy=0, so throughput is one word per N_BITS+1 cycles.
- start while busy=1 is ignored; din changes during busy have no effect.
- Boundary values:
  - din=0 gives mag=0, sign=0.
  - Most-negative value (1 followed by zeros) gives sign=1, mag=2^(N_BITS-1). This fits in N_BITS unsigned bits, so no overflow flag.
  - din=all-ones gives mag=1.
- Reset mid-operation: immediate abort to the reset state. No done pulse; partial mag is discarded (cleared).
- tp is one-hot at all times out of reset; an illegal or zero tp must recover to T0 on the next edge.

Decomposition:
- Shared package (complement pkg): N_BITS default, PULSES derivation, a typedef for the one-hot pulse vector, and a localparam for the T0 reset value.
- Natural sub-module: timing_pulse_gen. It is a one-hot ring with async reset, an advance enable, and self-recovery to T0, and it is reusable by the complement units.
- The serial datapath (shreg, seen_one, mag) stays in the top module.

Test Plan:
1. din=8'h05, start pulse for 1 cycle -> busy for 8 cycles; done at 9th edge after start; sign=0, mag=8'h05; tp walks T1..T8 then back to T0.
2. din=8'hFB (-5) -> sign=1, mag=8'h05. din=8'hFF -> sign=1, mag=8'h01. din=8'h80 -> sign=1, mag=8'h80. din=8'h00 -> sign=0, mag=8'h00.
3. Accept din=8'hF0; 3 cycles later assert start with din=8'h01 -> second start ignored; result sign=1, mag=8'h10, exactly one done.
4. Back-to-back: assert start with din=8'h7F in the done cycle of the previous conversion -> new conversion accepted immediately; second result sign=0, mag=8'h7F, with a gap of 9 edges between done pulses.
5. Assert rst asynchronously (between edges) at pulse T4 of a conversion of 8'h9C -> outputs go to reset values immediately: tp=T0, busy=0, mag=0. No done follows; the next conversion of 8'h9C yields sign=1, mag=8'h64.
6. Randomised sweep of all 256 values for N_BITS=8, plus N_BITS=4 with all 16 values -> mag equals |signed din| and sign equals the MSB for every value.

Source files
------------

// File: rtl/twos_to_signmag_pkg.sv
// Shared definitions for the complement datapath: default word width, timing-pulse
// ring sizing, the one-hot pulse vector type and its idle (T0) value.
package twos_to_signmag_pkg;

  localparam int N_BITS_DEFAULT = 8;

  // One pulse per bit plus the idle/load pulse T0.
  function automatic int pulses_for(input int n_bits);
    return n_bits + 1;
  endfunction

  localparam int PULSES_DEFAULT = pulses_for(N_BITS_DEFAULT);

  typedef logic [PULSES_DEFAULT-1:0] tp_vec_t;

  localparam tp_vec_t TP_T0 = tp_vec_t'(1);

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_RUN,
    PH_BAD
  } phase_e;

endpackage

// File: rtl/twos_to_signmag_timing_pulse_gen.sv
// One-hot timing-pulse ring T0..T(PULSES-1) with advance enable; any non-one-hot
// pattern falls back to T0 on the next edge.
module timing_pulse_gen
  import twos_to_signmag_pkg::*;
#(
  parameter int PULSES = PULSES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [PULSES-1:0] tp
);

  localparam logic [PULSES-1:0] T0 = PULSES'(TP_T0);

  logic [PULSES-1:0] tp_next;

  always_comb begin
    tp_next = T0;
    if ($onehot(tp)) begin
      tp_next = advance ? {tp[PULSES-2:0], tp[PULSES-1]} : tp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp <= T0;
    end else begin
      tp <= tp_next;
    end
  end

endmodule

// File: rtl/twos_to_signmag.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first, using the
// copy-until-first-one-then-invert rule, sequenced by a one-hot timing-pulse ring.
module twos_to_signmag
  import twos_to_signmag_pkg::*;
#(
  parameter  int N_BITS = N_BITS_DEFAULT,
  localparam int PULSES = N_BITS + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              sign,
  output logic [N_BITS-1:0] mag,
  output logic [PULSES-1:0] tp
);

  logic [N_BITS-1:0] shreg;
  logic              seen_one;
  logic              out_bit;
  logic              advance;
  phase_e            phase;

  timing_pulse_gen #(
    .PULSES(PULSES)
  ) u_tpg (
    .clk    (clk),
    .rst    (rst),
    .advance(advance),
    .tp     (tp)
  );

  // A corrupted ring is treated as neither idle nor running until it recovers.
  always_comb begin
    phase = PH_BAD;
    if ($onehot(tp)) begin
      phase = tp[0] ? PH_IDLE : PH_RUN;
    end
  end

  always_comb begin
    advance = 1'b1;
    if (phase == PH_IDLE) begin
      advance = start;
    end
  end

  assign busy = (phase == PH_RUN);

  // Positive words pass straight through; negative words copy bits up to and
  // including the first one, then invert the rest.
  always_comb begin
    out_bit = shreg[0];
    if (sign && seen_one) begin
      out_bit = ~shreg[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      seen_one <= 1'b0;
      sign     <= 1'b0;
      mag      <= '0;
      done     <= 1'b0;
    end else begin
      done <= (phase == PH_RUN) && tp[PULSES-1];
      case (phase)
        PH_IDLE: begin
          if (start) begin
            shreg    <= din;
            sign     <= din[N_BITS-1];
            seen_one <= 1'b0;
            mag      <= '0;
          end
        end
        PH_RUN: begin
          mag      <= {out_bit, mag[N_BITS-1:1]};
          shreg    <= {1'b0, shreg[N_BITS-1:1]};
          seen_one <= seen_one | shreg[0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule
